// File: rtl/pump_zone_scheduler_if.sv
// Signal bundle between the irrigation control side and the pump zone scheduler.
// The controller drives the request/enable inputs. The scheduler returns the valve and pump drives.
interface pump_zone_scheduler_if #(
    parameter int N_ZONES = 4,
    parameter int ZONE_W  = 2,
    parameter int CNT_W   = 6
);
    logic               tick_1hz;
    logic               enable;
    logic [N_ZONES-1:0] zone_req;
    logic               pesticide_lock;
    logic [N_ZONES-1:0] grant;
    logic               pump_on;
    logic [ZONE_W-1:0]  active_zone;
    logic [CNT_W-1:0]   sec_left;
    logic               busy;
    logic               slot_done;
    logic               timeout;

    modport master (
        output tick_1hz, enable, zone_req, pesticide_lock,
        input  grant, pump_on, active_zone, sec_left, busy, slot_done, timeout
    );

    modport slave (
        input  tick_1hz, enable, zone_req, pesticide_lock,
        output grant, pump_on, active_zone, sec_left, busy, slot_done, timeout
    );
endinterface

// File: rtl/pump_zone_scheduler.sv
// Round-robin time-sharing of one irrigation pump across N_ZONES valve lines.
// Each zone gets a bounded run slot. A pipe-drain dead time follows each slot.
module pump_zone_scheduler #(
    parameter int N_ZONES      = 4,
    parameter int ZONE_W       = 2,
    parameter int SLOT_SECONDS = 10,
    parameter int DEAD_SECONDS = 2,
    parameter int CNT_W        = 6
) (
    input  logic                  clk_50mhz,
    input  logic                  reset,
    pump_zone_scheduler_if.slave  bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SELECT = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_DEAD   = 2'd3;

    localparam logic [CNT_W-1:0] SLOT_LOAD = CNT_W'(SLOT_SECONDS);
    localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_SECONDS);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ZONE_W-1:0] LAST_RST = ZONE_W'(N_ZONES - 1);

    logic [1:0]         state_r, state_nx_s;
    logic [ZONE_W-1:0]  last_zone_r, last_nx_s;
    logic [ZONE_W-1:0]  active_zone_r, zone_nx_s;
    logic [CNT_W-1:0]   sec_left_r, sec_nx_s;
    logic [N_ZONES-1:0] grant_r, grant_nx_s;
    logic               pump_on_r, pump_nx_s;
    logic               busy_r, busy_nx_s;
    logic               slot_done_r, slot_done_nx_s;
    logic               timeout_r, timeout_nx_s;

    logic               start_ok_s;
    logic               pick_found_s;
    logic [ZONE_W-1:0]  pick_zone_s;
    logic               expire_s;
    logic               run_exit_s;

    function automatic logic [N_ZONES-1:0] zone_onehot(input logic [ZONE_W-1:0] zone);
        logic [N_ZONES-1:0] vec;
        vec       = '0;
        vec[zone] = 1'b1;
        return vec;
    endfunction

    // Walk offsets from farthest to nearest so the nearest requester after last is the one kept.
    function automatic logic [ZONE_W:0] pick_next(input logic [N_ZONES-1:0] req,
                                                  input logic [ZONE_W-1:0]  last);
        logic              found;
        logic [ZONE_W-1:0] zone;
        int                idx;
        found = 1'b0;
        zone  = '0;
        for (int i = N_ZONES; i >= 1; i--) begin
            idx = (int'(last) + i) % N_ZONES;
            if (req[idx]) begin
                found = 1'b1;
                zone  = ZONE_W'(idx);
            end else begin
                found = found;
            end
        end
        return {found, zone};
    endfunction

    assign start_ok_s                  = bus.enable & (|bus.zone_req) & ~bus.pesticide_lock;
    assign {pick_found_s, pick_zone_s} = pick_next(bus.zone_req, last_zone_r);
    assign expire_s                    = bus.tick_1hz & (sec_left_r == CNT_ONE);
    assign run_exit_s                  = expire_s | ~bus.zone_req[active_zone_r] |
                                         ~bus.enable | bus.pesticide_lock;

    // Next-state and next-output computation for the scheduler phases.
    always_comb begin
        state_nx_s     = state_r;
        last_nx_s      = last_zone_r;
        zone_nx_s      = active_zone_r;
        sec_nx_s       = sec_left_r;
        grant_nx_s     = '0;
        pump_nx_s      = 1'b0;
        slot_done_nx_s = 1'b0;
        timeout_nx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                sec_nx_s = '0;
                if (start_ok_s) begin
                    state_nx_s = ST_SELECT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SELECT: begin
                if (pick_found_s) begin
                    state_nx_s = ST_RUN;
                    zone_nx_s  = pick_zone_s;
                    last_nx_s  = pick_zone_s;
                    sec_nx_s   = SLOT_LOAD;
                    grant_nx_s = zone_onehot(pick_zone_s);
                    pump_nx_s  = 1'b1;
                end else begin
                    state_nx_s = ST_IDLE;
                    sec_nx_s   = '0;
                end
            end
            ST_RUN: begin
                // Any exit condition takes priority over the decrement.
                if (run_exit_s) begin
                    state_nx_s     = ST_DEAD;
                    sec_nx_s       = DEAD_LOAD;
                    slot_done_nx_s = 1'b1;
                    timeout_nx_s   = expire_s;
                end else begin
                    grant_nx_s = zone_onehot(active_zone_r);
                    pump_nx_s  = 1'b1;
                    if (bus.tick_1hz) begin
                        sec_nx_s = sec_left_r - CNT_ONE;
                    end else begin
                        sec_nx_s = sec_left_r;
                    end
                end
            end
            ST_DEAD: begin
                if (bus.tick_1hz) begin
                    if (sec_left_r == CNT_ONE) begin
                        sec_nx_s   = '0;
                        state_nx_s = start_ok_s ? ST_SELECT : ST_IDLE;
                    end else begin
                        sec_nx_s = sec_left_r - CNT_ONE;
                    end
                end else begin
                    sec_nx_s = sec_left_r;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                sec_nx_s   = '0;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_zone_r   <= LAST_RST;
            active_zone_r <= '0;
            sec_left_r    <= '0;
            grant_r       <= '0;
            pump_on_r     <= 1'b0;
            busy_r        <= 1'b0;
            slot_done_r   <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            last_zone_r   <= last_nx_s;
            active_zone_r <= zone_nx_s;
            sec_left_r    <= sec_nx_s;
            grant_r       <= grant_nx_s;
            pump_on_r     <= pump_nx_s;
            busy_r        <= busy_nx_s;
            slot_done_r   <= slot_done_nx_s;
            timeout_r     <= timeout_nx_s;
        end
    end

    assign bus.grant       = grant_r;
    assign bus.pump_on     = pump_on_r;
    assign bus.active_zone = active_zone_r;
    assign bus.sec_left    = sec_left_r;
    assign bus.busy        = busy_r;
    assign bus.slot_done   = slot_done_r;
    assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_pump_zone_scheduler.sv
// Directed bench for pump_zone_scheduler. The expected values are worked out by hand
// from the round-robin, slot and dead-time rules.
module tb_pump_zone_scheduler;

    logic clk_50mhz = 1'b0;
    logic reset     = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    pump_zone_scheduler_if #(.N_ZONES(4), .ZONE_W(2), .CNT_W(6)) bus ();

    pump_zone_scheduler #(
        .N_ZONES(4), .ZONE_W(2), .SLOT_SECONDS(10), .DEAD_SECONDS(2), .CNT_W(6)
    ) dut (
        .clk_50mhz (clk_50mhz),
        .reset     (reset),
        .bus       (bus)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_50mhz);
        #1;
    endtask

    task automatic do_tick();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".grant"},     32'(bus.grant),       32'h0);
        check({tag, ".pump"},      32'(bus.pump_on),     32'h0);
        check({tag, ".zone"},      32'(bus.active_zone), 32'h0);
        check({tag, ".sec"},       32'(bus.sec_left),    32'h0);
        check({tag, ".busy"},      32'(bus.busy),        32'h0);
        check({tag, ".slot_done"}, 32'(bus.slot_done),   32'h0);
        check({tag, ".timeout"},   32'(bus.timeout),     32'h0);
    endtask

    // Starts at the first RUN cycle. Runs the slot to expiry and the two-tick dead time.
    // Ends at the first RUN cycle of the next grant.
    task automatic full_slot(input string tag, input logic [3:0] exp_grant);
        check({tag, ".grant"}, 32'(bus.grant),    32'(exp_grant));
        check({tag, ".pump"},  32'(bus.pump_on),  32'h1);
        check({tag, ".sec10"}, 32'(bus.sec_left), 32'd10);
        repeat (9) do_tick();
        check({tag, ".sec1"},  32'(bus.sec_left), 32'd1);
        check({tag, ".hold"},  32'(bus.grant),    32'(exp_grant));
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        check({tag, ".done"},  32'(bus.slot_done), 32'h1);
        check({tag, ".tmo"},   32'(bus.timeout),   32'h1);
        check({tag, ".close"}, 32'(bus.grant),     32'h0);
        check({tag, ".poff"},  32'(bus.pump_on),   32'h0);
        check({tag, ".dead2"}, 32'(bus.sec_left),  32'd2);
        step();
        check({tag, ".donep"}, 32'(bus.slot_done), 32'h0);
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        check({tag, ".dead1"}, 32'(bus.sec_left), 32'd1);
        check({tag, ".gap"},   32'(bus.grant),    32'h0);
        step();
        bus.tick_1hz = 1'b1;
        step();
        bus.tick_1hz = 1'b0;
        check({tag, ".dead0"}, 32'(bus.sec_left), 32'd0);
        check({tag, ".sel"},   32'(bus.grant),    32'h0);
        step();
    endtask

    initial begin
        bus.tick_1hz       = 1'b0;
        bus.enable         = 1'b0;
        bus.zone_req       = 4'b0000;
        bus.pesticide_lock = 1'b0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;

        // A single requester gets zone 0 two cycles after the request, then again after the dead time.
        bus.enable   = 1'b1;
        bus.zone_req = 4'b0001;
        step();
        check("lat.sel_grant", 32'(bus.grant), 32'h0);
        check("lat.sel_busy",  32'(bus.busy),  32'h1);
        step();
        check("lat.zone", 32'(bus.active_zone), 32'd0);
        full_slot("single", 4'b0001);
        check("single.regrant", 32'(bus.grant), 32'b0001);

        // All four zones request, so the grants rotate through every zone.
        bus.zone_req = 4'b1111;
        full_slot("rr0", 4'b0001);
        full_slot("rr1", 4'b0010);
        full_slot("rr2", 4'b0100);
        full_slot("rr3", 4'b1000);
        check("rr.wrap", 32'(bus.grant), 32'b0001);

        // Only zone 2 requests. Dropping it at sec_left=7 closes the valve without a timeout.
        bus.zone_req = 4'b0100;
        step();
        check("drop0.done", 32'(bus.slot_done), 32'h1);
        check("drop0.tmo",  32'(bus.timeout),   32'h0);
        do_tick();
        do_tick();
        step();
        check("z2.grant", 32'(bus.grant),       32'b0100);
        check("z2.zone",  32'(bus.active_zone), 32'd2);
        repeat (3) do_tick();
        check("z2.sec7", 32'(bus.sec_left), 32'd7);
        bus.zone_req = 4'b1011;
        step();
        check("drop.grant", 32'(bus.grant),     32'h0);
        check("drop.pump",  32'(bus.pump_on),   32'h0);
        check("drop.done",  32'(bus.slot_done), 32'h1);
        check("drop.tmo",   32'(bus.timeout),   32'h0);
        check("drop.sec",   32'(bus.sec_left),  32'd2);
        check("drop.busy",  32'(bus.busy),      32'h1);
        do_tick();
        check("drop.dead1", 32'(bus.sec_left), 32'd1);
        do_tick();
        check("drop.next", 32'(bus.grant), 32'b1000);

        // The lock aborts zone 3. Holding it through the dead time leaves the scheduler idle.
        do_tick();
        bus.pesticide_lock = 1'b1;
        step();
        check("lock.grant", 32'(bus.grant),     32'h0);
        check("lock.done",  32'(bus.slot_done), 32'h1);
        check("lock.tmo",   32'(bus.timeout),   32'h0);
        check("lock.sec",   32'(bus.sec_left),  32'd2);
        do_tick();
        do_tick();
        check("lock.idle_busy", 32'(bus.busy),     32'h0);
        check("lock.idle_sec",  32'(bus.sec_left), 32'd0);
        check("lock.idle_gnt",  32'(bus.grant),    32'h0);
        bus.pesticide_lock = 1'b0;
        step();
        check("unlock.sel", 32'(bus.busy), 32'h1);
        step();
        check("unlock.grant", 32'(bus.grant), 32'b0001);

        // A tick at sec_left=1 arrives together with a request drop. The timeout wins and DEAD is entered once.
        repeat (9) do_tick();
        check("coin.sec1", 32'(bus.sec_left), 32'd1);
        bus.tick_1hz = 1'b1;
        bus.zone_req = 4'b1010;
        step();
        bus.tick_1hz = 1'b0;
        check("coin.done", 32'(bus.slot_done), 32'h1);
        check("coin.tmo",  32'(bus.timeout),   32'h1);
        check("coin.sec",  32'(bus.sec_left),  32'd2);
        step();
        check("coin.once",   32'(bus.slot_done), 32'h0);
        check("coin.tmo_p",  32'(bus.timeout),   32'h0);
        check("coin.sec_hd", 32'(bus.sec_left),  32'd2);
        do_tick();
        do_tick();
        check("coin.next", 32'(bus.grant), 32'b0010);

        // Reset during DEAD. Zone 3 is then granted with no dead time.
        bus.zone_req = 4'b1000;
        step();
        check("rdead.in_dead", 32'(bus.sec_left), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("rdead");
        step();
        check("rdead.sel", 32'(bus.grant), 32'h0);
        step();
        check("rdead.grant", 32'(bus.grant),       32'b1000);
        check("rdead.zone",  32'(bus.active_zone), 32'd3);

        // Reset during RUN. The pointer returns so that zone 0 wins over zone 3.
        do_tick();
        bus.zone_req = 4'b1001;
        reset        = 1'b1;
        step();
        reset = 1'b0;
        check_all_zero("rrun");
        step();
        step();
        check("rrun.grant", 32'(bus.grant),   32'b0001);
        check("rrun.pump",  32'(bus.pump_on), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pump_zone_scheduler.md
Name: pump_zone_scheduler

Overview:
- Time-shares the single irrigation pump among N_ZONES valve lines using round-robin order.
- Each zone gets a bounded run slot, followed by a pipe-drain dead time before the next valve opens.
- Sits between circuit_state/irrigation_state (enable, per-zone requests) and lines_control (valve grants, pump drive).
- Counts seconds from the 1 Hz enable derived by frequency_divider, resynchronised to clk_50mhz.

Parameters:
- N_ZONES, 4: number of valve lines sharing the pump.
- ZONE_W, 2: width of the zone index, equal to clog2(N_ZONES).
- SLOT_SECONDS, 10: maximum run seconds per grant.
- DEAD_SECONDS, 2: seconds with all valves closed and pump off between grants. Must be ≥1.
- CNT_W, 6: second-counter width. Must hold max(SLOT_SECONDS, DEAD_SECONDS).

Ports:
- clk_50mhz  in  1: single system clock.
- reset  in  1: synchronous, active-high.
- tick_1hz  in  1: one-cycle enable pulse, once per second, synchronous to clk_50mhz.
- enable  in  1: irrigation phase active (from circuit_state).
- zone_req  in  N_ZONES: per-zone watering request, level-sensitive.
- pesticide_lock  in  1: abort the current grant and block new grants while high.
- grant  out  N_ZONES: one-hot valve open; all-zero when no zone runs.
- pump_on  out  1: pump drive.
- active_zone  out  ZONE_W: index of the granted or last-granted zone.
- sec_left  out  CNT_W: remaining seconds of the current RUN or DEAD phase; 0 otherwise.
- busy  out  1: high in any state other than IDLE.
- slot_done  out  1: one-cycle pulse when RUN exits for any reason.
- timeout  out  1: one-cycle pulse, coincident with slot_done, only when exit was by slot expiry.

Behaviour:
- All outputs are registered.
- Reset values:
  - grant=0, pump_on=0, active_zone=0, sec_left=0, busy=0, slot_done=0, timeout=0.
  - Internal pointer last_zone=N_ZONES-1, so the first grant goes to zone 0.
  - State=IDLE.
- Reset mid-RUN or mid-DEAD closes the valves and stops the pump on the next edge. No dead time is applied after reset.
- IDLE:
  - Outputs inactive.
  - Go to SELECT when enable & |zone_req & !pesticide_lock.
- SELECT (exactly 1 cycle):
  - Pick the first requesting zone scanning last_zone+1, last_zone+2, … with wrap modulo N_ZONES. last_zone itself is scanned last.
  - Latch it into active_zone and last_zone; load sec_left=SLOT_SECONDS; go to RUN.
  - If requests vanished in this cycle, return to IDLE with no grant.
  - A tick_1hz in SELECT is ignored.
- RUN:
  - grant=one-hot(active_zone), pump_on=1.
  - Each tick_1hz decrements sec_left.
  - Exit conditions, evaluated each cycle:
    - (a) tick_1hz while sec_left==1, i.e. expiry; sets timeout.
    - (b) zone_req[active_zone]==0.
    - (c) enable==0.
    - (d) pesticide_lock==1.
  - On exit: go to DEAD; grant=0 and pump_on=0 on the same edge; sec_left=DEAD_SECONDS; slot_done pulses.
  - Simultaneous events: any exit condition wins over the decrement. timeout is set only when (a) holds, even if (b)–(d) also hold.
- DEAD:
  - grant=0, pump_on=0.
  - Each tick_1hz decrements sec_left.
  - Requests, enable and lock changes are ignored until the phase ends.
  - On the tick with sec_left==1: sec_left goes to 0, then next state is SELECT if enable & |zone_req & !pesticide_lock, else IDLE.
- Latency: request asserted in IDLE at cycle t gives SELECT at t+1 and grant/pump_on at t+2.
- Fairness: a continuously requesting zone cannot be granted twice in a row while any other zone requests.
- Single requester: a sole requesting zone is re-granted after each dead time.
- Invariants:
  - grant is never more than one-hot.
  - pump_on==|grant at all times.
  - No valve opens without at least DEAD_SECONDS ticks since the previous close, except the first grant after reset or after IDLE.

Test Plan:
- Reset, then enable=1, zone_req=0001 → grant=0001 and pump_on=1 two cycles after the request. After 10 ticks: slot_done=timeout=1 pulse, grant=0. After 2 more ticks: grant=0001 again.
- zone_req=1111 held, enable=1 → grant order 0001, 0010, 0100, 1000, 0001. Each grant lasts 10 ticks, separated by 2-tick all-zero gaps.
- Zone 2 running with sec_left=7, drop zone_req[2] → next edge grant=0, pump_on=0, slot_done=1, timeout=0. Then DEAD for 2 ticks.
- pesticide_lock=1 mid-RUN → immediate DEAD. Keep the lock high through DEAD → IDLE, no grant. Release lock → SELECT, and the next zone after the aborted one is granted.
- tick_1hz coincident with zone_req drop at sec_left=1 → timeout=1, slot_done=1, DEAD entered once.
- reset asserted during DEAD and during RUN → all outputs 0 next edge. Next request for zone 3 only grants 1000 with no dead time.
